// File: rtl/lfsr_gen_if.sv
// Handshake/data bundle for lfsr_gen: control and seed in, register state and event pulses out.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] data_out;
  logic             bit_out;
  logic             wrap;
  logic [WIDTH-1:0] period_out;
  logic             load_err;

  modport master (
    output en, load, seed,
    input  data_out, bit_out, wrap, period_out, load_err
  );

  modport slave (
    input  en, load, seed,
    output data_out, bit_out, wrap, period_out, load_err
  );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with multi-step advance, protected seed load and a
// wrap/period monitor. All outputs are registered.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int unsigned      STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic         clk,
  input logic         rst,
  lfsr_gen_if.slave   bus
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] start_reg;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period;
  logic             wrap_q;
  logic             load_err_q;
  logic [WIDTH-1:0] adv;

  // STEPS single shifts unrolled into one combinational stage
  always_comb begin
    adv = sreg;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv = {adv[WIDTH-2:0], ^(adv & TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg       <= SEED;
      start_reg  <= SEED;
      cnt        <= '0;
      period     <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        cnt <= '0;
        // an all-zero seed would lock the register up, so substitute 1
        if (bus.seed == '0) begin
          sreg       <= WIDTH'(1);
          start_reg  <= WIDTH'(1);
          load_err_q <= 1'b1;
        end else begin
          sreg      <= bus.seed;
          start_reg <= bus.seed;
        end
      end else if (bus.en) begin
        sreg <= adv;
        if (adv == start_reg) begin
          wrap_q <= 1'b1;
          period <= cnt + WIDTH'(1);
          cnt    <= '0;
        end else if (cnt != '1) begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end

  assign bus.data_out   = sreg;
  assign bus.bit_out    = sreg[WIDTH-1];
  assign bus.wrap       = wrap_q;
  assign bus.period_out = period;
  assign bus.load_err   = load_err_q;

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR for pseudo-random stimulus and timing generation in the lab FSM designs. It supports:
- configurable width and tap polynomial;
- multi-bit advance per enable;
- synchronous seed load with all-zero lock-up protection;
- a sequence-period monitor that pulses on wrap-around and reports the measured period.

It replaces fixed 8-bit LFSR instances wherever a programmable seed or period visibility is needed.

## Interface
- WIDTH, 8: register width; legal range 3..16.
- TAPS, 8'hB8: feedback mask, WIDTH bits; bit i set means sreg[i] feeds the XOR. TAPS[WIDTH-1] must be 1. The default gives x^8+x^6+x^5+x^4+1, which is maximal with period 255.
- STEPS, 1: shifts applied per enabled cycle; legal range 1..WIDTH.
- SEED, 1: reset value of the register; must be non-zero.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance the register by STEPS shifts this cycle.
- load  in  1  synchronous seed load; has priority over en.
- seed  in  WIDTH  value captured when load=1.
- data_out  out  WIDTH  current register state.
- bit_out  out  1  serial output, equal to data_out[WIDTH-1].
- wrap  out  1  one-cycle pulse: the register has just returned to its start state.
- period_out  out  WIDTH  number of enabled cycles in the last completed cycle of the sequence.
- load_err  out  1  one-cycle pulse: an all-zero seed was rejected.

## Operation
- **Single shift:** next = {sreg[WIDTH-2:0], ^(sreg & TAPS)}. This is a left shift with the feedback bit entering the LSB.
- **Enabled cycle (en=1, load=0):** sreg advances by STEPS single shifts, computed combinationally (unrolled) in one clock.
- **Start state:** the register value after reset (SEED) or after the latest load. It is held in an internal start_reg.
- **Load (load=1):**
  - sreg and start_reg take seed.
  - If seed == 0, both take 1 instead and load_err pulses.
  - The cycle counter clears; period_out is unchanged; wrap stays 0.
- **Cycle counter (cnt, WIDTH bits):**
  - Increments on each enabled cycle.
  - When the post-advance state equals start_reg: wrap=1, period_out <= cnt+1, cnt <= 0.
  - cnt saturates at all-ones and never wraps to 0 by overflow.
- **en=0, load=0:** all state holds; wrap and load_err are 0.
- **Zero state:** unreachable. Both SEED and load are non-zero, and the shift is invertible because TAPS[WIDTH-1]=1.
- **Simultaneous load and en:** load wins, and no advance is applied.
- **Wrap with STEPS>1:** the comparison uses only the post-advance state, so wrap fires after k enables where k·STEPS ≡ 0 mod the sequence period.

## Timing
- **Reset (asynchronous, immediate):**
  - data_out = SEED, bit_out = SEED[WIDTH-1].
  - start_reg = SEED, cnt = 0.
  - wrap = 0, period_out = 0, load_err = 0.
- **Registered outputs:** all outputs are registers or direct register slices. There is no combinational path from inputs to outputs.
- **Latency:**
  - A load or advance is visible on data_out one clock after the sampling edge.
  - wrap, period_out and load_err update on that same edge.
- **Pulse width:** wrap and load_err are high for exactly one cycle per event.
- **Reset mid-sequence:** the state returns to SEED immediately and the counter is lost. The first wrap after release occurs after a full period.

## Test plan
- **Defaults, reset then en=1 held:** data_out = 0x01, 0x02, 0x04, 0x08, 0x11, 0x23 on successive edges. bit_out tracks bit 7.
- **Full period, defaults:** 255 enables from reset leave data_out = 0x01. wrap pulses on the 255th edge only, and period_out = 255.
- **STEPS=2, SEED=1, default taps:** one enable gives 0x04, the next gives 0x11. wrap fires after 255 enables, with period_out = 255.
- **Load with en held:** load=1, en=1, seed=0x5A gives data_out = 0x5A and no advance. The next wrap occurs when the state returns to 0x5A after 255 enables.
- **Zero-seed rejection:** load with seed=0x00 gives data_out = 0x01 and a one-cycle load_err. Subsequent enables behave as after reset.
- **Asynchronous reset mid-run:** assert rst between edges after 100 enables. data_out goes to 0x01 and cnt clears without waiting for a clock; period_out and wrap are 0.
